// File: rtl/bus_pkg.sv
// Shared definitions for the processor bus: unit codes carried in
// address[15:12], the arbiter state encoding and default bus widths.
package bus_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 256;
  localparam int NUM_UNITS_DEF = 6;

  localparam logic [3:0] MainMemEn   = 4'd0;
  localparam logic [3:0] InstrMemEn  = 4'd1;
  localparam logic [3:0] MatrixAluEn = 4'd2;
  localparam logic [3:0] IntAluEn    = 4'd3;
  localparam logic [3:0] RegisterEn  = 4'd4;
  localparam logic [3:0] ExecuteEn   = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arbState_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: finds the first set request bit starting just above
// the pointer and wrapping around, so the last owner has lowest priority.
module rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          ptr_i,
  output logic                   valid_o,
  output logic [IW-1:0]          idx_o
);

  // Walk candidates ptr+1, ptr+2, ... modulo NUM_MASTERS and keep the first hit
  always_comb begin
    logic [IW-1:0] cand;
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IW'((int'(ptr_i) + k) % NUM_MASTERS);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin grant with one parked turnaround cycle,
// combinational owner mux onto the bus and one-hot unit decode.
// State updates on the falling edge of Clk. Defining ARB_TIMEOUT_EN adds an
// ownership watchdog with the err_timeout output.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_UNITS   = NUM_UNITS_DEF
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT   = 64
`endif
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_nRead,
  input  logic [NUM_MASTERS-1:0]        m_nWrite,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [ADDR_W-1:0]             address,
  output logic                          nRead,
  output logic                          nWrite,
  output logic [DATA_W-1:0]             DataOut,
  output logic [NUM_UNITS-1:0]          unit_sel,
  output logic                          err_illegal,
  output logic                          err_decode
`ifdef ARB_TIMEOUT_EN
  , output logic                        err_timeout
`endif
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arbState_e              state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          rrPtr_q;
  logic [IW-1:0]          owner_q;
  logic                   errIllegal_q;
  logic                   errDecode_q;

  logic [ADDR_W-1:0]      mAddr  [NUM_MASTERS];
  logic [DATA_W-1:0]      mWdata [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] pickReq;
  logic                   pickValid;
  logic [IW-1:0]          pickIdx;
  logic                   ownerRead;
  logic                   ownerWrite;
  logic                   illegalStrobe;
  logic                   decodeErr;
  logic [3:0]             unitCode;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]          ownCnt_q;
  logic [NUM_MASTERS-1:0] blocked_q;
  logic                   errTimeout_q;

  assign pickReq     = req & ~blocked_q;
  assign err_timeout = errTimeout_q;
`else
  assign pickReq = req;
`endif

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IW         (IW)
  ) uPicker (
    .req_i  (pickReq),
    .ptr_i  (rrPtr_q),
    .valid_o(pickValid),
    .idx_o  (pickIdx)
  );

  // Split the packed per-master buses into arrays indexed by master number
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      mAddr[m]  = m_addr[m*ADDR_W +: ADDR_W];
      mWdata[m] = m_wdata[m*DATA_W +: DATA_W];
    end
  end

  assign ownerRead     = m_nRead[owner_q];
  assign ownerWrite    = m_nWrite[owner_q];
  assign illegalStrobe = (state_q == OWN) && !ownerRead && !ownerWrite;
  assign unitCode      = address[ADDR_W-1 -: 4];
  assign decodeErr     = (state_q == OWN) && (!ownerRead || !ownerWrite) &&
                         (unitCode > 4'(NUM_UNITS - 1));

  // Owner drives the bus with no added latency; otherwise the bus is parked
  always_comb begin
    address = '0;
    DataOut = '0;
    nRead   = 1'b1;
    nWrite  = 1'b1;
    if (state_q == OWN) begin
      address = mAddr[owner_q];
      DataOut = mWdata[owner_q];
      nRead   = illegalStrobe ? 1'b1 : ownerRead;
      nWrite  = illegalStrobe ? 1'b1 : ownerWrite;
    end
  end

  // One-hot unit decode, silent for out-of-range codes and a parked bus
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_sel[u] = (state_q == OWN) && (unitCode == 4'(u));
    end
  end

  // Arbitration FSM with registered grant, round-robin pointer and sticky errors
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rrPtr_q      <= IW'(NUM_MASTERS - 1);
      owner_q      <= '0;
      errIllegal_q <= 1'b0;
      errDecode_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      ownCnt_q     <= '0;
      blocked_q    <= '0;
      errTimeout_q <= 1'b0;
`endif
    end else begin
      if (illegalStrobe) errIllegal_q <= 1'b1;
      if (decodeErr)     errDecode_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      blocked_q <= blocked_q & req;
`endif
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            gnt_q   <= NUM_MASTERS'(1) << pickIdx;
            owner_q <= pickIdx;
            state_q <= OWN;
`ifdef ARB_TIMEOUT_EN
            ownCnt_q <= '0;
`endif
          end
        end
        OWN: begin
          if (!req[owner_q]) begin
            gnt_q   <= '0;
            rrPtr_q <= owner_q;
            state_q <= TURN;
          end
`ifdef ARB_TIMEOUT_EN
          else if (ownCnt_q == CW'(TIMEOUT - 1)) begin
            gnt_q        <= '0;
            rrPtr_q      <= owner_q;
            state_q      <= TURN;
            errTimeout_q <= 1'b1;
            blocked_q    <= (blocked_q & req) | (NUM_MASTERS'(1) << owner_q);
          end else begin
            ownCnt_q <= ownCnt_q + 1'b1;
          end
`endif
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign err_illegal = errIllegal_q;
  assign err_decode  = errDecode_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: reset, single requester, contention,
// round-robin fairness, strobe gating and decode errors. The watchdog
// sequence runs only when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 256;

  logic             Clk = 1'b1;
  logic             nReset;
  logic [NM-1:0]    req;
  logic [NM*AW-1:0] mAddr;
  logic [NM-1:0]    mNRead;
  logic [NM-1:0]    mNWrite;
  logic [NM*DW-1:0] mWdata;
  logic [NM-1:0]    gnt;
  logic [AW-1:0]    address;
  logic             nRead;
  logic             nWrite;
  logic [DW-1:0]    DataOut;
  logic [5:0]       unit_sel;
  logic             err_illegal;
  logic             err_decode;
`ifdef ARB_TIMEOUT_EN
  logic             err_timeout;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [NM-1:0] expGnt [4];

  bus_arbiter #(
    .NUM_MASTERS(NM),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_UNITS  (6)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT  (8)
`endif
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .req        (req),
    .m_addr     (mAddr),
    .m_nRead    (mNRead),
    .m_nWrite   (mNWrite),
    .m_wdata    (mWdata),
    .gnt        (gnt),
    .address    (address),
    .nRead      (nRead),
    .nWrite     (nWrite),
    .DataOut    (DataOut),
    .unit_sel   (unit_sel),
    .err_illegal(err_illegal),
    .err_decode (err_decode)
`ifdef ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic applyStimulus(input int m, input logic [AW-1:0] a,
                               input logic rd, input logic wr,
                               input logic [DW-1:0] d);
    mAddr[m*AW +: AW]  = a;
    mNRead[m]          = rd;
    mNWrite[m]         = wr;
    mWdata[m*DW +: DW] = d;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge,
  // well away from the falling edge where the arbiter updates.
  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    data0 = {8{32'hDEADBEEF}};
    data1 = {8{32'h12345678}};
    expGnt[0] = 2'b01;
    expGnt[1] = 2'b10;
    expGnt[2] = 2'b01;
    expGnt[3] = 2'b10;

    nReset  = 1'b0;
    req     = '0;
    mAddr   = '0;
    mNRead  = '1;
    mNWrite = '1;
    mWdata  = '0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_gnt", DW'(gnt), DW'(2'b00));
    checkOutput("rst_addr", DW'(address), DW'(16'h0000));
    checkOutput("rst_nRead", DW'(nRead), DW'(1'b1));
    checkOutput("rst_nWrite", DW'(nWrite), DW'(1'b1));
    checkOutput("rst_data", DataOut, '0);
    checkOutput("rst_unit", DW'(unit_sel), DW'(6'b000000));
    checkOutput("rst_errs", DW'({err_illegal, err_decode}), DW'(2'b00));
    nextCycle();
    nReset = 1'b1;

    $display("[TB] single requester");
    req = 2'b01;
    applyStimulus(0, 16'h3001, 1'b1, 1'b0, data0);
    applyStimulus(1, 16'h5000, 1'b0, 1'b1, data1);
    #1;
    checkOutput("pre_gnt", DW'(gnt), DW'(2'b00));
    checkOutput("pre_park_addr", DW'(address), DW'(16'h0000));
    checkOutput("pre_park_unit", DW'(unit_sel), DW'(6'b000000));
    nextCycle();
    checkOutput("single_gnt", DW'(gnt), DW'(2'b01));
    checkOutput("single_addr", DW'(address), DW'(16'h3001));
    checkOutput("single_nWrite", DW'(nWrite), DW'(1'b0));
    checkOutput("nonowner_nRead", DW'(nRead), DW'(1'b1));
    checkOutput("single_unit", DW'(unit_sel), DW'(6'b001000));
    checkOutput("single_data", DataOut, data0);
    req = 2'b00;
    applyStimulus(0, 16'h0000, 1'b1, 1'b1, '0);
    applyStimulus(1, 16'h0000, 1'b1, 1'b1, '0);
    nextCycle();
    checkOutput("release_gnt", DW'(gnt), DW'(2'b00));
    nextCycle();

    $display("[TB] contention after reset");
    nReset = 1'b0;
    #1;
    nReset = 1'b1;
    req = 2'b11;
    nextCycle();
    checkOutput("tie_gnt", DW'(gnt), DW'(2'b01));
    nextCycle();
    req = 2'b10;
    nextCycle();
    checkOutput("drop_gnt", DW'(gnt), DW'(2'b00));
    nextCycle();
    checkOutput("turn_gnt", DW'(gnt), DW'(2'b00));
    nextCycle();
    checkOutput("handover_gnt", DW'(gnt), DW'(2'b10));

    $display("[TB] asynchronous reset mid-ownership");
    applyStimulus(1, 16'h2ABC, 1'b0, 1'b1, data1);
    #1;
    checkOutput("own1_addr", DW'(address), DW'(16'h2ABC));
    checkOutput("own1_unit", DW'(unit_sel), DW'(6'b000100));
    checkOutput("own1_data", DataOut, data1);
    nReset = 1'b0;
    #1;
    checkOutput("async_gnt", DW'(gnt), DW'(2'b00));
    checkOutput("async_nRead", DW'(nRead), DW'(1'b1));
    checkOutput("async_nWrite", DW'(nWrite), DW'(1'b1));
    checkOutput("async_addr", DW'(address), DW'(16'h0000));
    req = 2'b00;
    applyStimulus(1, 16'h0000, 1'b1, 1'b1, '0);
    nextCycle();
    nReset = 1'b1;

    $display("[TB] round-robin fairness");
    req = 2'b11;
    for (int r = 0; r < 4; r++) begin
      nextCycle();
      checkOutput($sformatf("rr_gnt%0d", r), DW'(gnt), DW'(expGnt[r]));
      nextCycle();
      nextCycle();
      req = 2'b11 & ~expGnt[r];
      nextCycle();
      checkOutput($sformatf("rr_rel%0d", r), DW'(gnt), DW'(2'b00));
      req = 2'b11;
      nextCycle();
    end
    req = 2'b00;
    nextCycle();

    $display("[TB] illegal strobes and decode errors");
    applyStimulus(0, 16'h1000, 1'b0, 1'b0, data0);
    req = 2'b01;
    nextCycle();
    checkOutput("ill_gnt", DW'(gnt), DW'(2'b01));
    checkOutput("ill_strobes", DW'({nRead, nWrite}), DW'(2'b11));
    checkOutput("ill_before", DW'(err_illegal), DW'(1'b0));
    nextCycle();
    checkOutput("ill_flag", DW'(err_illegal), DW'(1'b1));
    applyStimulus(0, 16'h1000, 1'b1, 1'b1, data0);
    nextCycle();
    checkOutput("ill_sticky", DW'(err_illegal), DW'(1'b1));
    checkOutput("dec_before", DW'(err_decode), DW'(1'b0));
    applyStimulus(0, 16'h7000, 1'b0, 1'b1, data0);
    #1;
    checkOutput("dec_unit", DW'(unit_sel), DW'(6'b000000));
    checkOutput("dec_nRead", DW'(nRead), DW'(1'b0));
    nextCycle();
    checkOutput("dec_flag", DW'(err_decode), DW'(1'b1));
    applyStimulus(0, 16'h5000, 1'b1, 1'b1, data0);
    #1;
    checkOutput("unit_code5", DW'(unit_sel), DW'(6'b100000));
    applyStimulus(0, 16'h6000, 1'b1, 1'b1, data0);
    #1;
    checkOutput("unit_code6", DW'(unit_sel), DW'(6'b000000));
    nextCycle();
    checkOutput("dec_sticky", DW'(err_decode), DW'(1'b1));
    req = 2'b00;
    applyStimulus(0, 16'h0000, 1'b1, 1'b1, '0);
    nReset = 1'b0;
    #1;
    checkOutput("err_clear", DW'({err_illegal, err_decode}), DW'(2'b00));
    nextCycle();
    nReset = 1'b1;

`ifdef ARB_TIMEOUT_EN
    $display("[TB] ownership watchdog");
    req = 2'b11;
    nextCycle();
    checkOutput("wd_gnt", DW'(gnt), DW'(2'b01));
    for (int i = 1; i < 8; i++) begin
      nextCycle();
      checkOutput($sformatf("wd_hold%0d", i), DW'(gnt), DW'(2'b01));
    end
    checkOutput("wd_flag_before", DW'(err_timeout), DW'(1'b0));
    nextCycle();
    checkOutput("wd_force", DW'(gnt), DW'(2'b00));
    checkOutput("wd_flag", DW'(err_timeout), DW'(1'b1));
    nextCycle();
    checkOutput("wd_turn", DW'(gnt), DW'(2'b00));
    nextCycle();
    checkOutput("wd_next", DW'(gnt), DW'(2'b10));
    for (int i = 0; i < 9; i++) nextCycle();
    req = 2'b00;
    nextCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the processor's single address/data/strobe bus between NUM_MASTERS requesters: the execution engine, a DMA loader and a debug port.
- Grants bus ownership one master at a time, with round-robin fairness and a one-cycle turnaround.
- Muxes the owner's address, strobes and write data onto the shared bus.
- Decodes address[15:12] into one-hot unit selects for main memory, instruction memory, matrix ALU, integer ALU, register file and execution engine.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 2..4.
- ADDR_W, 16, bus address width; bits [15:12] are the unit field.
- DATA_W, 256, write-data width.
- NUM_UNITS, 6, number of decoded unit selects (codes 0..5).
- TIMEOUT, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- Clk  in  1  bus clock; all state updates on the falling edge.
- nReset  in  1  reset, asynchronous, active-low.
- req  in  NUM_MASTERS  per-master bus request; held high for the whole ownership.
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address, packed, master 0 in the LSBs.
- m_nRead  in  NUM_MASTERS  per-master read strobe, active-low.
- m_nWrite  in  NUM_MASTERS  per-master write strobe, active-low.
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data, packed.
- gnt  out  NUM_MASTERS  one-hot grant, registered.
- address  out  ADDR_W  shared bus address.
- nRead  out  1  shared bus read strobe.
- nWrite  out  1  shared bus write strobe.
- DataOut  out  DATA_W  shared bus write data.
- unit_sel  out  NUM_UNITS  one-hot decode of address[15:12].
- err_illegal  out  1  sticky flag: owner drove nRead and nWrite low together.
- err_decode  out  1  sticky flag: a strobe was active while address[15:12] > 5.

Behaviour:
- Reset (asynchronous, any time, including mid-ownership):
  - state = IDLE, gnt = 0, rr_ptr = NUM_MASTERS-1, both error flags = 0.
  - address = 0, DataOut = 0, nRead = 1, nWrite = 1.
- State IDLE:
  - Bus is parked: address = 0, DataOut = 0, strobes = 1.
  - If any req bit is sampled high on a falling edge, the winner is the first set bit searched from rr_ptr+1 upward, wrapping modulo NUM_MASTERS.
  - On that same edge, gnt[winner] is set and the state moves to OWN.
  - Latency from req high to gnt high is 1 cycle.
- State OWN:
  - address, nRead, nWrite and DataOut follow the owner's inputs combinationally. No added latency, so existing master timing is unchanged.
  - Ownership lasts while req[owner] stays high. Other masters' requests are ignored; there is no preemption.
  - On the edge where req[owner] is sampled low: gnt = 0, rr_ptr = owner, state moves to TURN.
- State TURN:
  - Bus is parked for exactly 1 cycle, then the state moves to IDLE.
  - Re-arbitration in IDLE means a waiting master gets gnt 2 cycles after the previous owner drops req.
- A master that drops and re-raises req competes normally and has lowest priority relative to rr_ptr.
- Simultaneous requests are resolved by round-robin order only. After reset, master 0 wins a tie.
- Strobe gating:
  - Only the owner's strobes reach the bus. A non-owner's strobes are ignored.
  - If the owner drives nRead = 0 and nWrite = 0 together, both bus strobes are forced to 1 for that cycle and err_illegal sets.
- unit_sel:
  - Combinational one-hot of address[15:12] for codes 0..5; all zeros for codes 6..15 or when the bus is parked.
  - err_decode sets on a falling edge where the owner has a strobe low and the code is > 5.
- Error flags clear only on reset.
- gnt is never multi-hot and never changes outside a falling edge.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to OWN and increments each OWN cycle.
  - When it reaches TIMEOUT, the arbiter force-releases the owner: gnt = 0, state moves to TURN, rr_ptr = owner.
  - Output err_timeout (1 bit, sticky until reset) sets.
  - The forced-out master must drop req before it is eligible again.
- Without the macro: no counter, no err_timeout port, and ownership is unbounded.

Decomposition:
- Shared package bus_pkg holds:
  - unit code constants MainMemEn = 0, InstrMemEn = 1, MatrixAluEn = 2, IntAluEn = 3, RegisterEn = 4, ExecuteEn = 5;
  - the arbiter state enum {IDLE, OWN, TURN};
  - ADDR_W and DATA_W defaults.
- One sub-module is natural: rr_picker, a combinational round-robin first-set search from rr_ptr+1, parameterised by NUM_MASTERS.

Test Plan:
- Reset: nReset low mid-OWN with master 1 owning -> gnt = 00, nRead = nWrite = 1, address = 0 immediately, without waiting for a clock.
- Single requester: req = 01 -> gnt = 01 on the next falling edge. Master 0 drives address 16'h3001 with nWrite = 0 -> bus address = 16'h3001, nWrite = 0, unit_sel = 6'b001000.
- Contention: req = 11 after reset -> master 0 granted first. Master 0 drops req -> 1 TURN cycle -> gnt = 10 two cycles after the drop.
- Fairness: both masters request continuously, each dropping req 3 cycles after grant -> grants alternate 01, 10, 01, 10 with no starvation.
- Illegal strobe: owner drives nRead = 0, nWrite = 0 -> bus strobes both 1 and err_illegal = 1 until reset. Owner strobes with address 16'h7000 -> unit_sel = 0 and err_decode = 1.
- ARB_TIMEOUT_EN with TIMEOUT = 8: master 0 holds req 20 cycles -> gnt drops after 8 OWN cycles, err_timeout = 1, and a pending master 1 is granted 2 cycles later.
